// File: rtl/fact_pkg.sv
// Shared types and default sizing for the factorial request driver.
// Holds the sequencer state encoding and the timer-width helper.
package fact_pkg;

    localparam int NW_DEF           = 8;
    localparam int FW_DEF           = 32;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int START_HOLD_DEF   = 2;
    localparam int ACK_TIMEOUT_DEF  = 16;
    localparam int CALC_TIMEOUT_DEF = 4096;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        START    = 3'd2,
        ACK      = 3'd3,
        CALC     = 3'd4,
        ERR      = 3'd5,
        RESP     = 3'd6
    } state_t;

    // One shared timer must reach the largest of the three limits minus one.
    function automatic int timer_bits(input int a, input int b, input int c);
        int m;
        m = a;
        m = (b > m) ? b : m;
        m = (c > m) ? c : m;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/fact_req_fifo.sv
// Small synchronous operand buffer; occupancy tracked in a count register.
// Push is ignored when full, pop is ignored when empty.
module fact_req_fifo
    import fact_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    parameter int WIDTH = NW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == {CW{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {AW{1'b0}} : wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {AW{1'b0}} : rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fact_req_driver.sv
// Initiator for the factorial start/done handshake: buffers host operands,
// sequences each through the controller and returns result/error to the host.
module fact_req_driver
    import fact_pkg::*;
#(
    parameter int NW           = NW_DEF,
    parameter int FW           = FW_DEF,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int START_HOLD   = START_HOLD_DEF,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter int CALC_TIMEOUT = CALC_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [NW-1:0] req_n,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [FW-1:0] rsp_f,
    output logic          rsp_err,
    output logic          start,
    output logic [NW-1:0] n_out,
    input  logic          done,
    input  logic [FW-1:0] f_in,
    output logic          busy
);

    localparam int TW = timer_bits(START_HOLD, ACK_TIMEOUT, CALC_TIMEOUT);
    localparam logic [TW-1:0] T_ZERO    = {TW{1'b0}};
    localparam logic [TW-1:0] HOLD_LAST = TW'(START_HOLD - 1);
    localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] CALC_LAST = TW'(CALC_TIMEOUT - 1);

    state_t        state_r, state_s;
    logic [TW-1:0] timer_r, timer_s;
    logic          start_r, start_s;
    logic [NW-1:0] n_out_r, n_out_s;
    logic          rsp_valid_r, rsp_valid_s;
    logic [FW-1:0] rsp_f_r, rsp_f_s;
    logic          rsp_err_r, rsp_err_s;
    logic          pop_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic [NW-1:0] head_s;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t, input logic [TW-1:0] lim);
        return (t == lim) ? t : t + {{(TW-1){1'b0}}, 1'b1};
    endfunction

    fact_req_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(NW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && !fifo_full_s),
        .pop   (pop_s),
        .din   (req_n),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign req_ready = !fifo_full_s;
    assign start     = start_r;
    assign n_out     = n_out_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_f     = rsp_f_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = (state_r != IDLE) || !fifo_empty_s;

    // Sequencer next-state, timer and output decode.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        start_s     = start_r;
        n_out_s     = n_out_r;
        rsp_valid_s = rsp_valid_r;
        rsp_f_s     = rsp_f_r;
        rsp_err_s   = rsp_err_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s && !rsp_valid_r) begin
                    pop_s   = 1'b1;
                    n_out_s = head_s;
                    timer_s = T_ZERO;
                    state_s = WAIT_RDY;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_RDY: begin
                if (done) begin
                    start_s = 1'b1;
                    timer_s = T_ZERO;
                    state_s = START;
                end else if (timer_r == ACK_LAST) begin
                    state_s = ERR;
                end else begin
                    timer_s = sat_inc(timer_r, ACK_LAST);
                end
            end
            // done is deliberately not looked at while start is held.
            START: begin
                if (timer_r == HOLD_LAST) begin
                    start_s = 1'b0;
                    timer_s = T_ZERO;
                    state_s = ACK;
                end else begin
                    timer_s = sat_inc(timer_r, HOLD_LAST);
                end
            end
            ACK: begin
                if (!done) begin
                    timer_s = T_ZERO;
                    state_s = CALC;
                end else if (timer_r == ACK_LAST) begin
                    state_s = ERR;
                end else begin
                    timer_s = sat_inc(timer_r, ACK_LAST);
                end
            end
            CALC: begin
                if (done) begin
                    rsp_f_s     = f_in;
                    rsp_err_s   = 1'b0;
                    rsp_valid_s = 1'b1;
                    state_s     = RESP;
                end else if (timer_r == CALC_LAST) begin
                    state_s = ERR;
                end else begin
                    timer_s = sat_inc(timer_r, CALC_LAST);
                end
            end
            ERR: begin
                rsp_f_s     = {FW{1'b0}};
                rsp_err_s   = 1'b1;
                rsp_valid_s = 1'b1;
                state_s     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                start_s     = 1'b0;
                rsp_valid_s = 1'b0;
                timer_s     = T_ZERO;
                state_s     = IDLE;
            end
        endcase
    end

    // State, timer and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            timer_r     <= T_ZERO;
            start_r     <= 1'b0;
            n_out_r     <= {NW{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_f_r     <= {FW{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            start_r     <= start_s;
            n_out_r     <= n_out_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_f_r     <= rsp_f_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

endmodule

// File: tb/tb_fact_req_driver.sv
// Bench for fact_req_driver: behavioural factorial controller plus a
// scoreboard of expected responses filled as operands are pushed.
module tb_fact_req_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_n = 8'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_f;
    logic        rsp_err;
    logic        start;
    logic [7:0]  n_out;
    logic        done = 1'b1;
    logic [31:0] f_in = 32'd0;
    logic        busy;

    typedef struct {
        logic [31:0] f;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // controller model knobs and state
    int   mode = 0;         // 0 normal, 1 never acknowledges, 2 hangs in calc
    int   calc_lat = 4;
    bit   chk_lat = 1'b1;
    int   m_state = 0;
    int   m_cnt = 0;
    logic [7:0] m_n = 8'd0;
    bit   prev_start = 1'b0;
    int   hold_cnt = 0;
    int   start_rises = 0;

    fact_req_driver dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_err   (rsp_err),
        .start     (start),
        .n_out     (n_out),
        .done      (done),
        .f_in      (f_in),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fact(input logic [7:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 32'(i);
        return r;
    endfunction

    // behavioural factorial controller, acting on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (start && !prev_start) begin
                start_rises++;
                check_val("start_cond", {30'd0, done, rsp_valid}, 32'd2);
                hold_cnt = 0;
            end
            if (start) hold_cnt++;
            if (!start && prev_start) check_val("start_hold", hold_cnt, 32'd2);
            case (m_state)
                0: if (start && mode != 1) m_state = 1;
                1: if (!start) begin
                    m_n = n_out;
                    done = 1'b0;
                    m_cnt = (mode == 2) ? 5000 : calc_lat;
                    m_state = 2;
                end
                2: if (m_cnt > 0) m_cnt--;
                   else begin
                       f_in = fact(m_n);
                       done = 1'b1;
                       m_state = 3;
                   end
                default: begin
                    if (mode == 0 && chk_lat) check_val("rsp_lat", {31'd0, rsp_valid}, 32'd1);
                    m_state = 0;
                end
            endcase
            prev_start = start;
        end
    end

    // response monitor: a handshake completes on the next rising edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexp_rsp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("rsp_f", rsp_f, e.f);
                    check_val("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic push_req(input logic [7:0] n, input logic [31:0] ef, input logic ee);
        int b;
        b = 0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_n = n;
        exp_q.push_back('{f: ef, err: ee});
        @(negedge clk);
        while (!req_ready && b < 200) begin @(negedge clk); b++; end
        if (!req_ready) begin
            check_val("push_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            void'(exp_q.pop_back());
        end else begin
            @(posedge clk); #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin @(negedge clk); c++; end
        check_val("drain", exp_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int b;
        int n;
        int seen;
        int rises0;
        #1_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int n;
        int seen;
        int rises0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_start", {31'd0, start}, 32'd0);
        check_val("rst_n_out", {24'd0, n_out}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_f", rsp_f, 32'd0);
        check_val("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);

        // single request and start latency from the accepting edge
        push_req(8'd5, 32'd120, 1'b0);
        n = 0;
        while (!start && n < 20) begin @(negedge clk); n++; end
        check_val("start_lat", n, 32'd3);
        drain(200);

        // edge operands
        push_req(8'd0, 32'd1, 1'b0);
        push_req(8'd1, 32'd1, 1'b0);
        drain(300);

        // back-to-back under backpressure
        rsp_ready = 1'b0;
        push_req(8'd3, 32'd6, 1'b0);
        push_req(8'd4, 32'd24, 1'b0);
        push_req(8'd6, 32'd720, 1'b0);
        push_req(8'd2, 32'd2, 1'b0);
        push_req(8'd5, 32'd120, 1'b0);
        @(negedge clk);
        check_val("full_req_ready", {31'd0, req_ready}, 32'd0);
        b = 0;
        while (!rsp_valid && b < 200) begin @(negedge clk); b++; end
        rises0 = start_rises;
        repeat (10) @(negedge clk);
        check_val("hold_valid", {31'd0, rsp_valid}, 32'd1);
        check_val("hold_f", rsp_f, 32'd6);
        check_val("hold_no_start", start_rises, rises0);
        check_val("hold_busy", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain(500);

        // acknowledge timeout, then a healthy request
        mode = 1;
        push_req(8'd9, 32'd0, 1'b1);
        b = 0;
        while (!start && b < 50) begin @(negedge clk); b++; end
        b = 0;
        while (start && b < 50) begin @(negedge clk); b++; end
        n = 0;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        check_val("ack_to_lat", n, 32'd17);
        drain(100);
        mode = 0;
        push_req(8'd3, 32'd6, 1'b0);
        drain(200);

        // calculation timeout
        mode = 2;
        push_req(8'd4, 32'd0, 1'b1);
        drain(6000);
        check_val("calc_to_idle", {31'd0, busy}, 32'd0);
        b = 0;
        while (!(done && m_state == 0) && b < 2000) begin @(negedge clk); b++; end
        mode = 0;

        // asynchronous reset while calculating with two operands queued
        calc_lat = 50;
        rsp_ready = 1'b0;
        push_req(8'd3, 32'd6, 1'b0);
        push_req(8'd4, 32'd24, 1'b0);
        push_req(8'd5, 32'd120, 1'b0);
        b = 0;
        while (done && b < 50) begin @(negedge clk); b++; end
        chk_lat = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check_val("mid_rst_start", {31'd0, start}, 32'd0);
        check_val("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check_val("post_rst_no_rsp", seen, 32'd0);
        check_val("post_rst_busy", {31'd0, busy}, 32'd0);

        // recovery after reset
        b = 0;
        while (!(done && m_state == 0) && b < 200) begin @(negedge clk); b++; end
        chk_lat = 1'b1;
        calc_lat = 4;
        push_req(8'd4, 32'd24, 1'b0);
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
